posta_deconv_acc: RTL

Next-generation Winograd output (post-A) transform for the deconvolution engine. It accumulates NUM_CH transform-domain 6x6 patches, one input-channel beat at a time, then applies Y = A^T·P·A. Two selectable A^T matrices are supported: the deconv matrix and conv F(4,3). The result is a rounded, shifted and saturated 4x4 output tile. It sits between the element-wise multiplier array and the output writeback, with valid/ready handshakes on both sides.

---
 rtl/posta_deconv_acc.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/posta_deconv_acc.sv
// posta_deconv_acc
//   Winograd output (post-A) transform for the deconvolution engine.
//   Accumulates cfg_num_ch transform-domain 6x6 patches, then computes
//   Y = A^T * P * A with one of two A^T matrices. Each result element is
//   rounded, shifted and saturated, giving a 4x4 output tile.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   cfg_mode      0 = deconv A^T, 1 = conv F(4,3) A^T (captured on first beat)
//   cfg_num_ch    channel beats per tile, 0 treated as 1 (captured on first beat)
//   cfg_shift     rounding arithmetic right shift (captured on first beat)
//   s_valid/s_ready/s_patch   input patch stream (6x6 signed DATA_W)
//   m_valid/m_ready/m_patch   output tile stream (4x4 signed OUT_W)
//   m_sat         at least one element of m_patch was clipped
module posta_deconv_acc #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = DATA_W + 8,
  parameter int INT_W  = ACC_W + 8,
  parameter int OUT_W  = DATA_W,
  parameter int CH_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_mode,
  input  logic [CH_W-1:0]          cfg_num_ch,
  input  logic [4:0]               cfg_shift,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] s_patch [0:5][0:5],
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [OUT_W-1:0]  m_patch [0:3][0:3],
  output logic                     m_sat
);

  typedef enum logic [2:0] {IDLE, ACC, ROW, COL, OUT} state_t;

  localparam logic signed [INT_W-1:0] OUT_MAX = (INT_W'(1) <<< (OUT_W - 1)) - INT_W'(1);
  localparam logic signed [INT_W-1:0] OUT_MIN = ~OUT_MAX;

  state_t                   state, next_state;
  logic                     accept;
  logic [CH_W-1:0]          cnt;
  logic [CH_W-1:0]          num_q;
  logic [CH_W-1:0]          num_in;
  logic                     mode_q;
  logic [4:0]               shift_q;

  logic signed [ACC_W-1:0]  acc    [0:5][0:5];
  logic signed [INT_W-1:0]  t_reg  [0:3][0:5];
  logic signed [INT_W-1:0]  t_next [0:3][0:5];
  logic signed [INT_W-1:0]  z_full [0:3][0:3];
  logic signed [INT_W-1:0]  z_sh   [0:3][0:3];
  logic signed [OUT_W-1:0]  z_out  [0:3][0:3];
  logic signed [INT_W-1:0]  rnd;
  logic                     sat_any;

  // One row of A^T applied to a 6-element vector; coefficients are built
  // from shifts, adds and negations only.
  function automatic logic signed [INT_W-1:0] at_dot(
    input logic                    mode,
    input logic [1:0]              idx,
    input logic signed [INT_W-1:0] v0, v1, v2, v3, v4, v5
  );
    logic signed [INT_W-1:0] r;
    if (!mode) begin
      case (idx)
        2'd0:    r = v0 + v1;
        2'd1:    r = v3 + v4;
        2'd2:    r = v1 + v2;
        default: r = v4 + v5;
      endcase
    end else begin
      case (idx)
        2'd0:    r = v0 + v1 + v2 + v3 + v4;
        2'd1:    r = v1 - v2 + (v3 <<< 1) - (v4 <<< 1);
        2'd2:    r = v1 + v2 + (v3 <<< 2) + (v4 <<< 2);
        default: r = v1 - v2 + (v3 <<< 3) - (v4 <<< 3) + v5;
      endcase
    end
    return r;
  endfunction

  assign accept = s_valid && s_ready;
  assign num_in = (cfg_num_ch == '0) ? CH_W'(1) : cfg_num_ch;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = (num_in <= CH_W'(1)) ? ROW : ACC;
      ACC:  if (accept && (CH_W'(cnt + 1'b1) == num_q)) next_state = ROW;
      ROW:  next_state = COL;
      COL:  next_state = OUT;
      OUT:  if (m_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // s_ready is registered so it reads 0 throughout reset and rises on the
  // first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      s_ready <= 1'b0;
      cnt     <= '0;
      num_q   <= CH_W'(1);
      mode_q  <= 1'b0;
      shift_q <= '0;
    end else begin
      state   <= next_state;
      s_ready <= (next_state == IDLE) || (next_state == ACC);
      if (accept) begin
        if (state == IDLE) begin
          cnt     <= CH_W'(1);
          num_q   <= num_in;
          mode_q  <= cfg_mode;
          shift_q <= cfg_shift;
        end else begin
          cnt <= CH_W'(cnt + 1'b1);
        end
      end
    end
  end

  // Row stage: T = A^T * acc, one column of acc at a time.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 6; j++) begin
        t_next[i][j] = at_dot(mode_q, 2'(i),
                              INT_W'(acc[0][j]), INT_W'(acc[1][j]), INT_W'(acc[2][j]),
                              INT_W'(acc[3][j]), INT_W'(acc[4][j]), INT_W'(acc[5][j]));
      end
    end
  end

  // Column stage: Z = T * A, then round half up, shift and saturate.
  always_comb begin
    rnd     = (shift_q == 5'd0) ? '0 : (INT_W'(1) <<< (shift_q - 5'd1));
    sat_any = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        z_full[i][j] = at_dot(mode_q, 2'(j),
                              t_reg[i][0], t_reg[i][1], t_reg[i][2],
                              t_reg[i][3], t_reg[i][4], t_reg[i][5]);
        z_sh[i][j] = (z_full[i][j] + rnd) >>> shift_q;
        if (z_sh[i][j] > OUT_MAX) begin
          z_out[i][j] = OUT_MAX[OUT_W-1:0];
          sat_any     = 1'b1;
        end else if (z_sh[i][j] < OUT_MIN) begin
          z_out[i][j] = OUT_MIN[OUT_W-1:0];
          sat_any     = 1'b1;
        end else begin
          z_out[i][j] = z_sh[i][j][OUT_W-1:0];
        end
      end
    end
  end

  // NOTE: the datapath arrays are reset as well, so a tile interrupted by
  // reset leaves no stale partial sums and m_patch reads 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++)
        for (int j = 0; j < 6; j++) acc[i][j] <= '0;
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 6; j++) t_reg[i][j] <= '0;
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) m_patch[i][j] <= '0;
      m_valid <= 1'b0;
      m_sat   <= 1'b0;
    end else begin
      if (accept) begin
        for (int i = 0; i < 6; i++)
          for (int j = 0; j < 6; j++)
            acc[i][j] <= (state == IDLE) ? ACC_W'(s_patch[i][j])
                                         : acc[i][j] + ACC_W'(s_patch[i][j]);
      end
      if (state == ROW) t_reg <= t_next;
      if (state == COL) begin
        m_patch <= z_out;
        m_sat   <= sat_any;
        m_valid <= 1'b1;
      end else if (state == OUT && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule
